// File: rtl/mux4t1_pkg.sv
// Shared constants for the 4:1 select mux: default data width, select
// encodings and a small parity helper.
// Optional feature macro used by this slice: MUX4T1_PARITY_EN.
package mux4t1_pkg;

    // Default width of each data input and of the outputs.
    localparam int unsigned DEF_WIDTH = 4;

    // Select-code encodings; every 2-bit code is a valid selection.
    typedef enum logic [1:0] {
        SEL_I0 = 2'd0,
        SEL_I1 = 2'd1,
        SEL_I2 = 2'd2,
        SEL_I3 = 2'd3
    } sel_e;

    // Even parity: XOR reduction of a DEF_WIDTH-bit word.
    function automatic logic even_parity(input logic [DEF_WIDTH-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/mux4t1_sel_if.sv
// Bus bundle for mux4t1_sel: select code, four data inputs and the
// combinational and registered outputs.
// MUX4T1_PARITY_EN adds the registered parity bit o_par.
interface mux4t1_sel_if
    import mux4t1_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);

    logic [1:0]       s;
    logic [WIDTH-1:0] I0;
    logic [WIDTH-1:0] I1;
    logic [WIDTH-1:0] I2;
    logic [WIDTH-1:0] I3;
    logic [WIDTH-1:0] o;
    logic [WIDTH-1:0] o_q;
`ifdef MUX4T1_PARITY_EN
    logic             o_par;
`endif

    // Producer of select/data, consumer of the mux results.
    modport master (
        output s, I0, I1, I2, I3,
`ifdef MUX4T1_PARITY_EN
        input  o_par,
`endif
        input  o, o_q
    );

    // The mux itself.
    modport slave (
        input  s, I0, I1, I2, I3,
`ifdef MUX4T1_PARITY_EN
        output o_par,
`endif
        output o, o_q
    );

endinterface

// File: rtl/mux4t1_sel_mux2t1.sv
// WIDTH-parameterised 2:1 multiplexer, the building block of the 4:1 tree.
// An unknown select drives all-X rather than merging the two inputs.
module mux2t1
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Pure combinational select: sel=0 -> a, sel=1 -> b.
    always_comb begin
        y = 'x;
        case (sel)
            1'b0:    y = a;
            1'b1:    y = b;
            default: y = 'x;
        endcase
    end

endmodule

// File: rtl/mux4t1_sel.sv
// 4:1 WIDTH-bit mux with a zero-latency output o and a registered copy
// o_q (1-cycle latency, synchronous active-high reset to zero).
// Built as a two-level mux2t1 tree: s[0] picks within pairs, s[1] picks
// the pair. MUX4T1_PARITY_EN adds o_par, the even parity of o_q.
module mux4t1_sel
    import mux4t1_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    mux4t1_sel_if.slave   bus
);

    logic [WIDTH-1:0] lvl1_01;
    logic [WIDTH-1:0] lvl1_23;
    logic [WIDTH-1:0] o_mux;
    logic [WIDTH-1:0] o_q_r;

    mux2t1 #(.WIDTH(WIDTH)) u_mux_01 (
        .sel (bus.s[0]),
        .a   (bus.I0),
        .b   (bus.I1),
        .y   (lvl1_01)
    );

    mux2t1 #(.WIDTH(WIDTH)) u_mux_23 (
        .sel (bus.s[0]),
        .a   (bus.I2),
        .b   (bus.I3),
        .y   (lvl1_23)
    );

    mux2t1 #(.WIDTH(WIDTH)) u_mux_out (
        .sel (bus.s[1]),
        .a   (lvl1_01),
        .b   (lvl1_23),
        .y   (o_mux)
    );

    assign bus.o   = o_mux;
    assign bus.o_q = o_q_r;

    // Output register: captures the combinational result each edge; reset wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_q_r <= '0;
        end else begin
            o_q_r <= o_mux;
        end
    end

`ifdef MUX4T1_PARITY_EN
    logic o_par_r;

    assign bus.o_par = o_par_r;

    // Parity register: computed from the value being loaded so it tracks o_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_par_r <= 1'b0;
        end else begin
            o_par_r <= ^o_mux;
        end
    end
`endif

endmodule

// File: tb/tb_mux4t1_sel.sv
// Self-checking bench for mux4t1_sel: directed cases plus random stimulus,
// compared against an array-indexing reference model.
// Build with +define+MUX4T1_PARITY_EN to also check o_par.
module tb_mux4t1_sel;
    import mux4t1_pkg::*;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   sel = '0;
    logic [W-1:0] din [4];

    logic [W-1:0] q_model   = '0;
    logic         par_model = 1'b0;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    mux4t1_sel_if #(.WIDTH(W)) bus ();

    assign bus.s  = sel;
    assign bus.I0 = din[0];
    assign bus.I1 = din[1];
    assign bus.I2 = din[2];
    assign bus.I3 = din[3];

    mux4t1_sel #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference: registered copy of the selected input word, cleared by reset.
    always @(posedge clk) begin
        q_model   <= rst ? '0 : din[sel];
        par_model <= rst ? 1'b0 : (din[sel][0] ^ din[sel][1] ^ din[sel][2] ^ din[sel][3]);
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic set_in(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] c, input logic [W-1:0] d);
        din[0] = a; din[1] = b; din[2] = c; din[3] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_in('0, '0, '0, '0);

        // Reset state
        tick(); tick();
        check("reset_o_q", bus.o_q, '0);
        @(negedge clk);
        rst = 1'b0;

        // Combinational select, ascending data
        set_in(4'h0, 4'h1, 4'h2, 4'h3);
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            #1 check("comb_asc", bus.o, 4'(i));
        end

        // Alternating pattern, then back to s=0
        set_in(4'h5, 4'hA, 4'h5, 4'hA);
        sel = SEL_I0; #1 check("alt_s0", bus.o, 4'h5);
        sel = SEL_I1; #1 check("alt_s1", bus.o, 4'hA);
        sel = SEL_I2; #1 check("alt_s2", bus.o, 4'h5);
        sel = SEL_I3; #1 check("alt_s3", bus.o, 4'hA);
        sel = SEL_I0; #1 check("alt_back_s0", bus.o, 4'h5);

        // Unselected inputs have no effect
        sel = SEL_I2;
        set_in(4'h1, 4'h2, 4'h9, 4'h3);
        #1 check("unsel_base", bus.o, 4'h9);
        din[0] = 4'hF; #1 check("unsel_I0", bus.o, 4'h9);
        din[1] = 4'hE; #1 check("unsel_I1", bus.o, 4'h9);
        din[3] = 4'hC; #1 check("unsel_I3", bus.o, 4'h9);
        din[2] = 4'h7; #1 check("sel_I2_change", bus.o, 4'h7);

        // Reset overrides load; o stays live during reset
        @(negedge clk);
        sel = SEL_I1; din[1] = 4'hA;
        tick();
        check("load_before_rst", bus.o_q, 4'hA);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("rst_o_q", bus.o_q, '0);
        check("rst_o_live", bus.o, 4'hA);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("rst_release_load", bus.o_q, 4'hA);

        // o_q trails o by one cycle while s steps 0..3
        @(negedge clk);
        set_in(4'h0, 4'h1, 4'h2, 4'h3);
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            tick();
            check("step_o_q", bus.o_q, 4'(i));
            @(negedge clk);
        end

`ifdef MUX4T1_PARITY_EN
        // Parity of the registered value
        set_in(4'h7, 4'h5, 4'h0, 4'h0);
        sel = SEL_I0; tick();
        check("par_q7", bus.o_q, 4'h7);
        check("par_7", 4'(bus.o_par), 4'd1);
        @(negedge clk);
        sel = SEL_I1; tick();
        check("par_5", 4'(bus.o_par), 4'd0);
        @(negedge clk);
`endif

        // Random stimulus against the reference model
        for (int n = 0; n < 60; n++) begin
            set_in(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            sel = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 9) == 0);
            #1 check("rand_o", bus.o, din[sel]);
            tick();
            check("rand_o_q", bus.o_q, q_model);
`ifdef MUX4T1_PARITY_EN
            check("rand_o_par", 4'(bus.o_par), 4'(par_model));
`endif
            @(negedge clk);
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Safety net so the run always ends on its own.
    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
